// File: rtl/ace_audio_pkg.sv
// Shared widths, default beeper weights and helpers for the Jupiter ACE audio mixer.
package ace_audio_pkg;

    localparam int unsigned RAW_W = 17;
    localparam int unsigned SUM_W = 18;
    localparam int unsigned PCM_W = 16;
    localparam int unsigned AYX_W = 13;

    localparam logic [15:0] DEF_SPK_W = 16'd7168;
    localparam logic [15:0] DEF_EAR_W = 16'd896;
    localparam logic [15:0] DEF_MIC_W = 16'd127;

    localparam logic [PCM_W-1:0] PCM_MAX = 16'h7FFF;

    typedef struct packed {
        logic [AYX_W-1:0] a13;
        logic [AYX_W-1:0] b13;
        logic [AYX_W-1:0] c13;
        logic             mono;
    } ay_stage_t;

    // Replicating the top bits makes FF map to full scale 8191.
    function automatic logic [AYX_W-1:0] ay_expand(input logic [7:0] lvl);
        return {lvl, lvl[7:3]};
    endfunction

    function automatic logic [PCM_W-1:0] sat_pcm(input logic [SUM_W-1:0] v);
        if (v > {2'b00, PCM_MAX}) begin
            return PCM_MAX;
        end else begin
            return v[PCM_W-1:0];
        end
    endfunction

endpackage

// File: rtl/beeper_lpf.sv
// Beeper level generator with a snap-to-target IIR low-pass that removes clicks.
module beeper_lpf
    import ace_audio_pkg::*;
#(
    parameter logic [15:0] SPK_W      = DEF_SPK_W,
    parameter logic [15:0] EAR_W      = DEF_EAR_W,
    parameter logic [15:0] MIC_W      = DEF_MIC_W,
    parameter int unsigned FILT_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             spk,
    input  logic             ear_s,
    input  logic             mic,
    output logic [RAW_W-1:0] acc
);

    localparam logic signed [SUM_W-1:0] SNAP_LIM = 18'sd1 <<< FILT_SHIFT;

    logic [RAW_W-1:0]        raw_s;
    logic signed [SUM_W-1:0] diff_s;
    logic signed [SUM_W-1:0] mag_s;
    logic signed [SUM_W-1:0] step_s;
    logic [RAW_W-1:0]        acc_nxt_s;
    logic [RAW_W-1:0]        acc_r;

    // Target level and next accumulator; snapping once within a step lets it settle exactly.
    always_comb begin
        raw_s  = (spk   ? {1'b0, SPK_W} : 17'd0)
               + (ear_s ? {1'b0, EAR_W} : 17'd0)
               + (mic   ? {1'b0, MIC_W} : 17'd0);
        diff_s = $signed({1'b0, raw_s}) - $signed({1'b0, acc_r});
        mag_s  = diff_s[SUM_W-1] ? -diff_s : diff_s;
        step_s = diff_s >>> FILT_SHIFT;
        if ((FILT_SHIFT == 32'd0) || (mag_s < SNAP_LIM)) begin
            acc_nxt_s = raw_s;
        end else begin
            acc_nxt_s = acc_r + RAW_W'(step_s);
        end
    end

    // Accumulator advances only on the sample strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_nxt_s;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/ace_audio_mixer.sv
// Three-stage sample-strobed mixer: beeper filter + AY expand, channel sum, saturate/mute.
module ace_audio_mixer
    import ace_audio_pkg::*;
#(
    parameter logic [15:0] SPK_W      = DEF_SPK_W,
    parameter logic [15:0] EAR_W      = DEF_EAR_W,
    parameter logic [15:0] MIC_W      = DEF_MIC_W,
    parameter int unsigned FILT_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic             spk,
    input  logic             mic,
    input  logic             ear,
    input  logic [7:0]       ay_a,
    input  logic [7:0]       ay_b,
    input  logic [7:0]       ay_c,
    input  logic             mono,
    input  logic             mute,
    output logic [PCM_W-1:0] audio_l,
    output logic [PCM_W-1:0] audio_r,
    output logic             audio_valid
);

    logic             ear_meta_r;
    logic             ear_sync_r;
    logic             s1_vld_r;
    logic             s2_vld_r;
    logic             out_vld_r;
    ay_stage_t        ay_r;
    logic [RAW_W-1:0] beep_s;
    logic [SUM_W-1:0] mix_l_s;
    logic [SUM_W-1:0] mix_r_s;
    logic [SUM_W-1:0] mix_l_r;
    logic [SUM_W-1:0] mix_r_r;
    logic [PCM_W-1:0] pcm_l_s;
    logic [PCM_W-1:0] pcm_r_s;
    logic [PCM_W-1:0] audio_l_r;
    logic [PCM_W-1:0] audio_r_r;

    // Two-flop synchroniser for the asynchronous EAR pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ear_meta_r <= 1'b0;
            ear_sync_r <= 1'b0;
        end else begin
            ear_meta_r <= ear;
            ear_sync_r <= ear_meta_r;
        end
    end

    beeper_lpf #(
        .SPK_W      (SPK_W),
        .EAR_W      (EAR_W),
        .MIC_W      (MIC_W),
        .FILT_SHIFT (FILT_SHIFT)
    ) u_lpf (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sample_en),
        .spk     (spk),
        .ear_s   (ear_sync_r),
        .mic     (mic),
        .acc     (beep_s)
    );

    // Stage 1: capture expanded AY levels and the mode alongside the filter update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_r <= 1'b0;
            ay_r     <= '0;
        end else begin
            s1_vld_r <= sample_en;
            if (sample_en) begin
                ay_r.a13  <= ay_expand(ay_a);
                ay_r.b13  <= ay_expand(ay_b);
                ay_r.c13  <= ay_expand(ay_c);
                ay_r.mono <= mono;
            end
        end
    end

    // Stage 2 sums: ACB stereo puts C in both channels.
    always_comb begin
        if (ay_r.mono) begin
            mix_l_s = {1'b0, beep_s} + SUM_W'(ay_r.a13) + SUM_W'(ay_r.b13) + SUM_W'(ay_r.c13);
            mix_r_s = mix_l_s;
        end else begin
            mix_l_s = {1'b0, beep_s} + SUM_W'(ay_r.a13) + SUM_W'(ay_r.c13);
            mix_r_s = {1'b0, beep_s} + SUM_W'(ay_r.b13) + SUM_W'(ay_r.c13);
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld_r <= 1'b0;
            mix_l_r  <= '0;
            mix_r_r  <= '0;
        end else begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                mix_l_r <= mix_l_s;
                mix_r_r <= mix_r_s;
            end
        end
    end

    // Stage 3 saturation; mute is deliberately sampled here, not at stage 1.
    always_comb begin
        if (mute) begin
            pcm_l_s = 16'd0;
            pcm_r_s = 16'd0;
        end else begin
            pcm_l_s = sat_pcm(mix_l_r);
            pcm_r_s = sat_pcm(mix_r_r);
        end
    end

    // Output registers hold between valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_r <= 1'b0;
            audio_l_r <= '0;
            audio_r_r <= '0;
        end else begin
            out_vld_r <= s2_vld_r;
            if (s2_vld_r) begin
                audio_l_r <= pcm_l_s;
                audio_r_r <= pcm_r_s;
            end
        end
    end

    assign audio_l     = audio_l_r;
    assign audio_r     = audio_r_r;
    assign audio_valid = out_vld_r;

endmodule

// File: tb/tb_ace_audio_mixer.sv
// Self-checking bench: three mixer instances (filter bypass, filtered, high speaker weight)
// compared every cycle against a timestamped behavioural model, plus directed vectors.
module tb_ace_audio_mixer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sample_en = 1'b0;
    logic spk = 1'b0;
    logic mic = 1'b0;
    logic ear = 1'b0;
    logic mono = 1'b0;
    logic mute = 1'b0;
    logic [7:0] ay_a = 8'd0;
    logic [7:0] ay_b = 8'd0;
    logic [7:0] ay_c = 8'd0;
    logic [15:0] audio_l [NI];
    logic [15:0] audio_r [NI];
    logic        audio_valid [NI];

    ace_audio_mixer #(.FILT_SHIFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .spk(spk), .mic(mic), .ear(ear),
        .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c), .mono(mono), .mute(mute),
        .audio_l(audio_l[0]), .audio_r(audio_r[0]), .audio_valid(audio_valid[0]));

    ace_audio_mixer #(.FILT_SHIFT(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .spk(spk), .mic(mic), .ear(ear),
        .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c), .mono(mono), .mute(mute),
        .audio_l(audio_l[1]), .audio_r(audio_r[1]), .audio_valid(audio_valid[1]));

    ace_audio_mixer #(.SPK_W(16'd16383), .FILT_SHIFT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .spk(spk), .mic(mic), .ear(ear),
        .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c), .mono(mono), .mute(mute),
        .audio_l(audio_l[2]), .audio_r(audio_r[2]), .audio_valid(audio_valid[2]));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int spkw_m [NI] = '{7168, 7168, 16383};
    int fs_m   [NI] = '{0, 2, 0};
    int acc_m  [NI];
    int exp_l  [NI];
    int exp_r  [NI];
    bit exp_v  [NI];
    bit ear_q1, ear_q2;
    int ec;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int inst;
        int l;
        int r;
        int due;
    } pend_t;
    pend_t pend[$];

    function automatic int ay13(int x);
        return x * 32 + x / 8;
    endfunction

    function automatic int floor_div(int n, int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int clip(int v);
        return (v > 32767) ? 32767 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            acc_m[i] = 0; exp_l[i] = 0; exp_r[i] = 0; exp_v[i] = 1'b0;
        end
        pend.delete();
        ear_q1 = 1'b0;
        ear_q2 = 1'b0;
    endtask

    task automatic model_edge();
        pend_t keep[$];
        int raw, diff, ad, a, b, c, l, r;
        ec++;
        if (!reset_n) return;
        for (int i = 0; i < NI; i++) exp_v[i] = 1'b0;
        foreach (pend[k]) begin
            if (pend[k].due == ec) begin
                exp_v[pend[k].inst] = 1'b1;
                exp_l[pend[k].inst] = mute ? 0 : clip(pend[k].l);
                exp_r[pend[k].inst] = mute ? 0 : clip(pend[k].r);
            end else begin
                keep.push_back(pend[k]);
            end
        end
        pend = keep;
        if (sample_en) begin
            a = ay13(int'(ay_a)); b = ay13(int'(ay_b)); c = ay13(int'(ay_c));
            for (int i = 0; i < NI; i++) begin
                raw  = (spk ? spkw_m[i] : 0) + (ear_q2 ? 896 : 0) + (mic ? 127 : 0);
                diff = raw - acc_m[i];
                ad   = (diff < 0) ? -diff : diff;
                if (fs_m[i] == 0 || ad < (1 << fs_m[i])) acc_m[i] = raw;
                else acc_m[i] = acc_m[i] + floor_div(diff, 1 << fs_m[i]);
                if (mono) begin
                    l = acc_m[i] + a + b + c; r = l;
                end else begin
                    l = acc_m[i] + a + c; r = acc_m[i] + b + c;
                end
                pend.push_back('{i, l, r, ec + 2});
            end
        end
        ear_q2 = ear_q1;
        ear_q1 = ear;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, int inst, int act, int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, inst, act, expv, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("valid", i, int'(audio_valid[i]), int'(exp_v[i]));
            chk("audio_l", i, int'(audio_l[i]), exp_l[i]);
            chk("audio_r", i, int'(audio_r[i]), exp_r[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic lpf_sample(output int v);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        chk("lpf_valid", 1, int'(audio_valid[1]), 1);
        v = int'(audio_l[1]);
        tick();
    endtask

    // ---------------- directed vectors (filter-bypass instances) ----------------
    typedef struct {
        logic spk, mic, ear, mono, mute;
        logic [7:0] a, b, c;
        int l0, r0, l2, r2;
    } vec_t;
    vec_t vecs[8];

    task automatic apply_vec(int idx);
        spk = vecs[idx].spk; mic = vecs[idx].mic; ear = vecs[idx].ear;
        mono = vecs[idx].mono; mute = vecs[idx].mute;
        ay_a = vecs[idx].a; ay_b = vecs[idx].b; ay_c = vecs[idx].c;
        repeat (3) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        chk($sformatf("vec%0d_valid", idx), 0, int'(audio_valid[0]), 1);
        chk($sformatf("vec%0d_l", idx), 0, int'(audio_l[0]), vecs[idx].l0);
        chk($sformatf("vec%0d_r", idx), 0, int'(audio_r[0]), vecs[idx].r0);
        chk($sformatf("vec%0d_l", idx), 2, int'(audio_l[2]), vecs[idx].l2);
        chk($sformatf("vec%0d_r", idx), 2, int'(audio_r[2]), vecs[idx].r2);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int cur, prev, got, vcnt, first, last;
        int first3[3] = '{1792, 3136, 4144};
        int outs[16];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 7168, 7168, 16383, 16383};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h80, 20494, 12303, 29709, 21518};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 8'h30, 3084, 3084, 3084, 3084};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 32764, 32764, 32767, 32767};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 255, 287, 255, 287};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 896, 896, 896, 896};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};

        ec = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        #2;
        reset_n = 1'b1;

        // Latency: idle gives no valid, then exactly t+3 after a single strobe.
        repeat (4) tick();
        spk = 1'b1;
        sample_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            sample_en = 1'b0;
            chk($sformatf("latency_c%0d", k), 0, int'(audio_valid[0]), (k == 3) ? 1 : 0);
        end

        // Reset during activity discards in-flight samples.
        sample_en = 1'b1;
        ay_a = 8'h55;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", i, int'(audio_valid[i]), 0);
            chk("rst_l", i, int'(audio_l[i]), 0);
            chk("rst_r", i, int'(audio_r[i]), 0);
        end
        tick();
        sample_en = 1'b0;
        tick();
        #2;
        reset_n = 1'b1;
        repeat (5) tick();

        for (int v = 0; v < 8; v++) apply_vec(v);
        mute = 1'b0;

        // Filtered step response up to the speaker level and back down.
        spk = 1'b0; mic = 1'b0; ear = 1'b0; mono = 1'b0;
        ay_a = 8'd0; ay_b = 8'd0; ay_c = 8'd0;
        repeat (3) tick();
        do_reset();
        spk = 1'b1;
        prev = 0; got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            lpf_sample(cur);
            if (k < 3) chk($sformatf("lpf_step%0d", k), 1, cur, first3[k]);
            chk("lpf_rise_monotonic", 1, int'(cur >= prev), 1);
            prev = cur;
            if (cur == 7168) got = 1;
        end
        chk("lpf_settle_high", 1, prev, 7168);
        repeat (2) begin
            lpf_sample(cur);
            chk("lpf_hold_high", 1, cur, 7168);
        end
        spk = 1'b0;
        got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            lpf_sample(cur);
            chk("lpf_fall_monotonic", 1, int'(cur <= prev), 1);
            prev = cur;
            if (cur == 0) got = 1;
        end
        chk("lpf_settle_low", 1, prev, 0);

        // Ten back-to-back strobes with mute toggled mid-burst.
        do_reset();
        spk = 1'b1;
        sample_en = 1'b1;
        vcnt = 0; first = -1; last = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 10) sample_en = 1'b0;
            if (c == 4) mute = 1'b1;
            if (c == 7) mute = 1'b0;
            tick();
            if (audio_valid[1]) begin
                if (vcnt < 16) outs[vcnt] = int'(audio_l[1]);
                vcnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("burst_valid_count", 1, vcnt, 10);
        chk("burst_valid_span", 1, last - first + 1, 10);
        chk("burst_muted_sample", 1, outs[3], 0);
        chk("mute_filter_runs", 1, int'(outs[5] > outs[1]), 1);

        // Randomised traffic, including one asynchronous reset mid-stream.
        for (int n = 0; n < 400; n++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            spk  = 1'($urandom_range(0, 1));
            mic  = 1'($urandom_range(0, 1));
            ear  = 1'($urandom_range(0, 1));
            ay_a = 8'($urandom_range(0, 255));
            ay_b = 8'($urandom_range(0, 255));
            ay_c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) mono = ~mono;
            mute = ($urandom_range(0, 9) == 0);
            if (n == 200) do_reset();
            else tick();
        end
        sample_en = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
